bmem_arbiter: RTL and testbench

- Sits between the CPU's instruction cache, its data cache and the burst memory (bmem).
- Arbitrates line requests from both caches and issues them one at a time to bmem.
- Reads: collects 64-bit return beats into a 256-bit line.
- Writes: serializes a 256-bit line into 64-bit write beats.
- Replaces the read-only cacheline adapter and adds write-back support for the data-cache path.

---
 rtl/bmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bmem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares the burst memory between the instruction and data caches.
// Reads gather four 64-bit beats into a 256-bit line; dcache write-backs are
// sent as four 64-bit beats. One bmem transaction is outstanding at a time.
// Optional build macro BMEM_ARB_RR_EN: round-robin between the two ports
// instead of fixed dcache priority.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | sample requests, pick owner, latch line-aligned address
// RD_CMD     | hold bmem_read until bmem accepts it
// RD_COLLECT | gather beats whose raddr matches the latched address
// WR_BEATS   | present write beats, advance only on bmem_ready
// RESP       | one-cycle completion pulse to the owner
module bmem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_read,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic [ADDR_WIDTH-1:0] bmem_addr,
   output logic                  bmem_read,
   output logic                  bmem_write,
   output logic [BEAT_WIDTH-1:0] bmem_wdata,
   input  logic                  bmem_ready,
   input  logic [ADDR_WIDTH-1:0] bmem_raddr,
   input  logic [BEAT_WIDTH-1:0] bmem_rdata,
   input  logic                  bmem_rvalid
);

   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CW    = $clog2(BEATS);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(31);

   typedef enum logic [2:0] {IDLE, RD_CMD, RD_COLLECT, WR_BEATS, RESP} state_t;

   state_t                state, state_nx;
   logic                  owner;        // 1 = dcache, 0 = icache
   logic [ADDR_WIDTH-1:0] addr;
   logic [CW-1:0]         cnt;
   logic [LINE_WIDTH-1:0] line, line_nx;
   logic                  d_req, pick_d, beat_ok, last_beat;

   assign d_req     = d_read | d_write;
   assign last_beat = (cnt == CW'(BEATS - 1));
   assign beat_ok   = (state == RD_COLLECT) && bmem_rvalid && (bmem_raddr == addr);

`ifdef BMEM_ARB_RR_EN
   logic rr_last;   // owner served most recently; the other port is favoured

   assign pick_d = d_req && (!i_read || !rr_last);

   // Record the served port as the FSM enters RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_last <= 1'b0;
      else if (state_nx == RESP && state != RESP)
         rr_last <= owner;
   end
`else
   assign pick_d = d_req;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state decode and bmem/response outputs.
   always_comb begin
      state_nx   = state;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      case (state)
         IDLE: begin
            if (pick_d)
               state_nx = d_write ? WR_BEATS : RD_CMD;
            else if (i_read)
               state_nx = RD_CMD;
         end
         RD_CMD: begin
            bmem_read = 1'b1;
            bmem_addr = addr;
            if (bmem_ready)
               state_nx = RD_COLLECT;
         end
         RD_COLLECT: begin
            if (beat_ok && last_beat)
               state_nx = RESP;
         end
         WR_BEATS: begin
            bmem_write = 1'b1;
            bmem_addr  = addr;
            bmem_wdata = d_wdata[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH];
            if (bmem_ready && last_beat)
               state_nx = RESP;
         end
         RESP: begin
            i_resp   = ~owner;
            d_resp   = owner;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Line with the current return beat merged in at its slot.
   always_comb begin
      line_nx = line;
      line_nx[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH] = bmem_rdata;
   end

   // Owner/address latch, beat counter and line assembly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner   <= 1'b0;
         addr    <= '0;
         cnt     <= '0;
         line    <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_d) begin
                  owner <= 1'b1;
                  addr  <= d_addr & LINE_MASK;
               end else if (i_read) begin
                  owner <= 1'b0;
                  addr  <= i_addr & LINE_MASK;
               end
            end
            RD_COLLECT: begin
               if (beat_ok) begin
                  line <= line_nx;
                  cnt  <= last_beat ? '0 : cnt + CW'(1);
                  if (last_beat) begin
                     if (owner)
                        d_rdata <= line_nx;
                     else
                        i_rdata <= line_nx;
                  end
               end
            end
            WR_BEATS: begin
               if (bmem_ready)
                  cnt <= last_beat ? '0 : cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed testbench for bmem_arbiter: icache fill, dcache write-back with
// stalls, contention, foreign beats, async reset mid-collect, write-then-read.
module tb_bmem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  i_addr, d_addr, bmem_addr, bmem_raddr;
   logic         i_read, i_resp, d_read, d_write, d_resp;
   logic [255:0] i_rdata, d_rdata, d_wdata;
   logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
   logic [63:0]  bmem_wdata, bmem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   bmem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [31:0] a, input logic [63:0] d);
      bmem_rvalid = 1'b1;
      bmem_raddr  = a;
      bmem_rdata  = d;
      tick();
      bmem_rvalid = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_bmem_read"},  bmem_read,  0);
      chk({tag, "_bmem_write"}, bmem_write, 0);
      chk({tag, "_bmem_addr"},  bmem_addr,  0);
      chk({tag, "_bmem_wdata"}, bmem_wdata, 0);
      chk({tag, "_i_resp"},     i_resp,     0);
      chk({tag, "_d_resp"},     d_resp,     0);
      chk({tag, "_i_rdata"},    i_rdata,    0);
      chk({tag, "_d_rdata"},    d_rdata,    0);
   endtask

   localparam logic [63:0] W0 = 64'h0123_4567_89ab_cdef;
   localparam logic [63:0] W1 = 64'hfedc_ba98_7654_3210;
   localparam logic [63:0] W2 = 64'h0f0f_0f0f_a5a5_5a5a;
   localparam logic [63:0] W3 = 64'hdead_beef_cafe_f00d;

   initial begin
      rst = 1'b1;
      i_addr = '0; i_read = 0; d_addr = '0; d_read = 0; d_write = 0; d_wdata = '0;
      bmem_ready = 0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;
      #2;
      chk_idle_outputs("reset");
      tick();
      rst = 1'b0;
      tick();

      // icache fill
      i_read = 1; i_addr = 32'h1eceb004; bmem_ready = 1;
      tick();
      chk("t1_bmem_read", bmem_read, 1);
      chk("t1_bmem_addr", bmem_addr, 32'h1eceb000);
      tick();
      chk("t1_read_once", bmem_read, 0);
      beat(32'h1eceb000, {8{8'h11}});
      beat(32'h1eceb000, {8{8'h22}});
      beat(32'h1eceb000, {8{8'h33}});
      chk("t1_no_early_resp", i_resp, 0);
      beat(32'h1eceb000, {8{8'h44}});
      chk("t1_i_resp", i_resp, 1);
      chk("t1_d_resp", d_resp, 0);
      chk("t1_i_rdata", i_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
      i_read = 0;
      tick();
      chk("t1_resp_one_cycle", i_resp, 0);

      // dcache write-back with a two-cycle stall on beat 1
      d_write = 1; d_addr = 32'h1eceb020; d_wdata = {W3, W2, W1, W0};
      tick();
      chk("t2_write_b0", bmem_write, 1);
      chk("t2_addr", bmem_addr, 32'h1eceb020);
      chk("t2_no_read", bmem_read, 0);
      chk("t2_wdata0", bmem_wdata, W0);
      tick();
      chk("t2_wdata1", bmem_wdata, W1);
      bmem_ready = 0;
      tick();
      chk("t2_stall1_write", bmem_write, 1);
      chk("t2_stall1_wdata", bmem_wdata, W1);
      tick();
      chk("t2_stall2_wdata", bmem_wdata, W1);
      bmem_ready = 1;
      tick();
      chk("t2_wdata2", bmem_wdata, W2);
      tick();
      chk("t2_wdata3", bmem_wdata, W3);
      chk("t2_no_early_resp", d_resp, 0);
      tick();
      chk("t2_d_resp", d_resp, 1);
      chk("t2_write_off", bmem_write, 0);
      chk("t2_i_resp", i_resp, 0);
      d_write = 0;
      tick();
      chk("t2_resp_one_cycle", d_resp, 0);

      // contention: D first, then I; foreign beat and RD_CMD stall during I
      i_read = 1; i_addr = 32'h0000_1044; d_read = 1; d_addr = 32'h0000_2068;
      tick();
      chk("t3_d_first_addr", bmem_addr, 32'h0000_2060);
      chk("t3_d_first_read", bmem_read, 1);
      tick();
      beat(32'h0000_2060, 64'hd0);
      beat(32'h0000_2060, 64'hd1);
      beat(32'h0000_2060, 64'hd2);
      beat(32'h0000_2060, 64'hd3);
      chk("t3_d_resp", d_resp, 1);
      chk("t3_i_not_resp", i_resp, 0);
      chk("t3_d_rdata", d_rdata, {64'hd3, 64'hd2, 64'hd1, 64'hd0});
      d_read = 0;
      tick();
      chk("t3_idle_gap", bmem_read, 0);
      bmem_ready = 0;
      tick();
      chk("t3_i_addr", bmem_addr, 32'h0000_1040);
      chk("t3_i_read", bmem_read, 1);
      tick();
      chk("t3_cmd_held", bmem_read, 1);
      chk("t3_cmd_held_addr", bmem_addr, 32'h0000_1040);
      bmem_ready = 1;
      tick();
      chk("t3_cmd_done", bmem_read, 0);
      beat(32'h0000_0000, {16{4'hf}});
      tick();
      beat(32'h0000_1040, 64'ha0);
      beat(32'h0000_1040, 64'ha1);
      beat(32'h0000_1040, 64'ha2);
      beat(32'h0000_1040, 64'ha3);
      chk("t3_i_resp", i_resp, 1);
      chk("t3_i_rdata", i_rdata, {64'ha3, 64'ha2, 64'ha1, 64'ha0});
      i_read = 0;
      tick();

      // async reset in the middle of a collect
      i_read = 1; i_addr = 32'h0000_3000;
      tick();
      tick();
      beat(32'h0000_3000, 64'hb0);
      beat(32'h0000_3000, 64'hb1);
      rst = 1'b1;
      i_read = 0;
      #1;
      chk_idle_outputs("t4_rst");
      beat(32'h0000_3000, 64'hb2);
      rst = 1'b0;
      beat(32'h0000_3000, 64'hb3);
      chk("t4_no_resp_a", i_resp, 0);
      tick();
      chk("t4_no_resp_b", i_resp, 0);
      chk("t4_no_cmd", bmem_read, 0);
      i_read = 1;
      tick();
      chk("t4_refill_cmd", bmem_read, 1);
      chk("t4_refill_addr", bmem_addr, 32'h0000_3000);
      tick();
      beat(32'h0000_3000, 64'hc0);
      beat(32'h0000_3000, 64'hc1);
      beat(32'h0000_3000, 64'hc2);
      beat(32'h0000_3000, 64'hc3);
      chk("t4_refill_resp", i_resp, 1);
      chk("t4_refill_rdata", i_rdata, {64'hc3, 64'hc2, 64'hc1, 64'hc0});
      i_read = 0;
      tick();

      // write and read together: write first, read after re-presenting
      d_write = 1; d_read = 1; d_addr = 32'h0000_4040; d_wdata = {W0, W1, W2, W3};
      tick();
      chk("t5_write_first", bmem_write, 1);
      chk("t5_not_read", bmem_read, 0);
      chk("t5_wdata0", bmem_wdata, W3);
      tick();
      chk("t5_wdata1", bmem_wdata, W2);
      tick();
      tick();
      chk("t5_wdata3", bmem_wdata, W0);
      tick();
      chk("t5_d_resp", d_resp, 1);
      chk("t5_rdata_held", d_rdata, 0);
      d_write = 0; d_read = 0;
      tick();
      d_read = 1;
      tick();
      chk("t5_read_cmd", bmem_read, 1);
      chk("t5_read_addr", bmem_addr, 32'h0000_4040);
      chk("t5_no_write", bmem_write, 0);
      tick();
      beat(32'h0000_4040, 64'he0);
      beat(32'h0000_4040, 64'he1);
      beat(32'h0000_4040, 64'he2);
      beat(32'h0000_4040, 64'he3);
      chk("t5_read_resp", d_resp, 1);
      chk("t5_read_rdata", d_rdata, {64'he3, 64'he2, 64'he1, 64'he0});
      d_read = 0;
      tick();
      chk("t5_back_idle", d_resp, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
